ram_port_master: RTL

- Request/response front-end that drives one port of the dual-port byte-masked RAM (cen/wen/bwen/addr/din in, registered dout out, 1-cycle read latency).
- Converts a valid/ready request stream into RAM port cycles.
- Captures read data into a 2-entry response FIFO so the consumer can apply backpressure without losing data.
- Flags out-of-range addresses when DEPTH is not a power of two.

---
 rtl/ram_port_master.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ram_port_master.sv
// rtl/ram_port_master.sv - request/response front-end for one port of a byte-masked RAM
//
// Purpose: turns a valid/ready request stream into RAM port cycles and buffers
// read data (1-cycle RAM latency) in a 2-entry response FIFO so the consumer
// may apply backpressure. Reads beyond DEPTH return zero data with rsp_err set.
//
// Ports:
//   clock, reset_n                     clock (rising edge), async active-low reset
//   req_valid/req_ready                request handshake
//   req_wen/req_bwen/req_addr/req_wdata request fields (1 = write)
//   rsp_valid/rsp_ready                response handshake
//   rsp_rdata/rsp_err                  response payload, registered from FIFO head
//   ram_cen/ram_wen/ram_bwen/ram_addr/ram_din  RAM port command
//   ram_dout                           RAM read data, valid the cycle after a read
module ram_port_master #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int BWEN_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [BWEN_WIDTH-1:0] req_bwen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  ram_cen,
  output logic                  ram_wen,
  output logic [BWEN_WIDTH-1:0] ram_bwen,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  // One extra bit so DEPTH itself is representable in the comparison.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  // Response FIFO entry: {err, data}
  logic [DATA_WIDTH:0] fifo_q [2];
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d;
  logic                inflight_q, inflight_d;
  logic                err_q, err_d;

  logic                in_range;
  logic                acc;
  logic                push;
  logic                pop;
  logic [1:0]          occ;
  logic [DATA_WIDTH:0] push_entry;

  assign in_range = ({1'b0, req_addr} < DEPTH_W);
  assign occ      = count_q + {1'b0, inflight_q};
  assign pop      = rsp_valid && rsp_ready;

  // A pop in the same cycle frees a slot, so ready may follow rsp_ready
  // combinationally; this sustains one request per cycle under full flow.
  assign req_ready = reset_n && ((occ < 2'd2) || pop);
  assign acc       = req_valid && req_ready;

  // RAM command is a combinational pass-through, held at zero during reset.
  assign ram_cen  = acc && in_range;
  assign ram_wen  = reset_n && req_wen;
  assign ram_bwen = (reset_n && req_wen) ? req_bwen : '0;
  assign ram_addr = reset_n ? req_addr : '0;
  assign ram_din  = reset_n ? req_wdata : '0;

  // The read launched last cycle lands now; out-of-range reads never touched
  // the RAM, so their data is forced to zero.
  assign push       = inflight_q;
  assign push_entry = {err_q, (err_q ? {DATA_WIDTH{1'b0}} : ram_dout)};

  assign rsp_valid = (count_q != 2'd0);
  assign rsp_rdata = fifo_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign rsp_err   = fifo_q[rd_ptr_q][DATA_WIDTH];

  always_comb begin
    inflight_d = acc && !req_wen;
    err_d      = err_q;
    if (acc && !req_wen) begin
      err_d = !in_range;
    end
    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= push_entry;
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

endmodule
